// File: rtl/mult_div_unit_pkg.sv
// Shared funct codes and FSM state type for the HI/LO multiply/divide unit.
package mult_div_unit_pkg;

  localparam logic [5:0] FUNCT_MFHI  = 6'h10;
  localparam logic [5:0] FUNCT_MTHI  = 6'h11;
  localparam logic [5:0] FUNCT_MFLO  = 6'h12;
  localparam logic [5:0] FUNCT_MTLO  = 6'h13;
  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  function automatic logic is_long_op(input logic [5:0] f);
    return (f == FUNCT_MULT) || (f == FUNCT_MULTU) ||
           (f == FUNCT_DIV)  || (f == FUNCT_DIVU);
  endfunction

  function automatic logic is_signed_op(input logic [5:0] f);
    return (f == FUNCT_MULT) || (f == FUNCT_DIV);
  endfunction

  function automatic logic is_div_op(input logic [5:0] f);
    return (f == FUNCT_DIV) || (f == FUNCT_DIVU);
  endfunction

endpackage

// File: rtl/mult_div_unit_muldiv_step.sv
// One iteration of unsigned shift-add multiply or restoring shift-subtract divide.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] operand,
  input  logic             is_div,
  output logic [WIDTH-1:0] acc_next,
  output logic [WIDTH-1:0] q_next
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;

  // Multiply: {acc,q} shifts right, multiplier bits consumed from q[0].
  // Divide: {acc,q} shifts left, quotient bits enter at q[0].
  always_comb begin
    sum      = {1'b0, acc} + {1'b0, operand};
    shifted  = {acc, q[WIDTH-1]};
    diff     = shifted[WIDTH-1:0] - operand;
    acc_next = acc;
    q_next   = q;
    if (is_div) begin
      if (shifted >= {1'b0, operand}) begin
        acc_next = diff;
        q_next   = {q[WIDTH-2:0], 1'b1};
      end else begin
        acc_next = shifted[WIDTH-1:0];
        q_next   = {q[WIDTH-2:0], 1'b0};
      end
    end else if (q[0]) begin
      acc_next = sum[WIDTH:1];
      q_next   = {sum[0], q[WIDTH-1:1]};
    end else begin
      acc_next = {1'b0, acc[WIDTH-1:1]};
      q_next   = {acc[0], q[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// HI/LO multiply/divide unit: iterative MULT/MULTU/DIV/DIVU plus MTHI/MTLO writes.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [5:0]       fncode,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  state_t           state, state_next;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc, q, operand;
  logic [WIDTH-1:0] acc_step, q_step;
  logic             run_div, neg_lo, neg_hi;

  logic             accept, long_op, signed_op, div_op, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] quot_fix, rem_fix;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .acc      (acc),
    .q        (q),
    .operand  (operand),
    .is_div   (run_div),
    .acc_next (acc_step),
    .q_next   (q_step)
  );

  always_comb begin
    accept     = start && (state == IDLE);
    long_op    = is_long_op(fncode);
    signed_op  = is_signed_op(fncode);
    div_op     = is_div_op(fncode);
    a_neg      = signed_op && op_a[WIDTH-1];
    b_neg      = signed_op && op_b[WIDTH-1];
    a_mag      = a_neg ? -op_a : op_a;
    b_mag      = b_neg ? -op_b : op_b;
    state_next = state;
    unique case (state)
      IDLE: if (accept && long_op) state_next = RUN;
      RUN:  if (cnt == CW'(WIDTH - 1)) state_next = FIX;
      FIX:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Sign correction on the unsigned magnitude result; neg_lo is the product
  // sign for multiply and the quotient sign for divide.
  always_comb begin
    prod_fix = neg_lo ? -{acc, q} : {acc, q};
    quot_fix = neg_lo ? -q : q;
    rem_fix  = neg_hi ? -acc : acc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next != IDLE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi      <= '0;
      lo      <= '0;
      acc     <= '0;
      q       <= '0;
      operand <= '0;
      cnt     <= '0;
      run_div <= 1'b0;
      neg_lo  <= 1'b0;
      neg_hi  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept && fncode == FUNCT_MTHI) hi <= op_a;
          if (accept && fncode == FUNCT_MTLO) lo <= op_a;
          if (accept && long_op) begin
            acc     <= '0;
            q       <= div_op ? a_mag : b_mag;
            operand <= div_op ? b_mag : a_mag;
            cnt     <= '0;
            run_div <= div_op;
            neg_lo  <= a_neg ^ b_neg;
            neg_hi  <= div_op && a_neg;
          end
        end
        RUN: begin
          acc <= acc_step;
          q   <= q_step;
          cnt <= cnt + 1'b1;
        end
        FIX: begin
          if (run_div) begin
            hi <= rem_fix;
            lo <= quot_fix;
          end else begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Randomized self-checking bench for mult_div_unit against an arithmetic reference model.
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [5:0]  fncode = '0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        busy;
  logic [31:0] hi, lo;

  int          vectors = 0;
  int          miscompares = 0;
  int          busy_cnt = 0;
  logic [31:0] mhi = '0;
  logic [31:0] mlo = '0;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .fncode (fncode),
    .op_a   (op_a),
    .op_b   (op_b),
    .busy   (busy),
    .hi     (hi),
    .lo     (lo)
  );

  always #5 clk = ~clk;

  // Architectural result {hi,lo} straight from the instruction definitions.
  function automatic logic [63:0] refModel(input logic [5:0] fn, input logic [31:0] a, b,
                                           input logic [31:0] h, l);
    longint          sa, sb, sq, sr;
    longint unsigned ua, ub;
    logic [63:0]     p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (fn)
      FUNCT_MULT:  begin p = sa * sb; return p; end
      FUNCT_MULTU: begin p = ua * ub; return p; end
      FUNCT_DIV: begin
        if (b == 0) return {a, (a[31] ? 32'd1 : 32'hFFFF_FFFF)};
        sq = sa / sb;
        sr = sa % sb;
        return {sr[31:0], sq[31:0]};
      end
      FUNCT_DIVU: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        p = {ua % ub, 32'b0} | (ua / ub);
        return p;
      end
      FUNCT_MTHI: return {a, l};
      FUNCT_MTLO: return {h, a};
      default:    return {h, l};
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (busy) busy_cnt++;
  endtask

  task automatic waitIdle(input string tag);
    int guard;
    guard = 0;
    while (busy && guard < 100) begin
      guard++;
      tick();
    end
    if (guard >= 100) checkOutput({tag, ":timeout"}, 64'(guard), 64'd0);
  endtask

  // Issues one request, waits for completion, checks busy length and HI/LO.
  task automatic applyStimulus(input string tag, input logic [5:0] fn, input logic [31:0] a, b);
    logic [63:0] exp;
    exp      = refModel(fn, a, b, mhi, mlo);
    busy_cnt = 0;
    start    = 1'b1;
    fncode   = fn;
    op_a     = a;
    op_b     = b;
    tick();
    start    = 1'b0;
    if (is_long_op(fn)) begin
      repeat (5) tick();
      checkOutput({tag, ":hold"}, {hi, lo}, {mhi, mlo});
    end
    waitIdle(tag);
    checkOutput({tag, ":busy"}, 64'(busy_cnt), is_long_op(fn) ? 64'd33 : 64'd0);
    checkOutput({tag, ":hilo"}, {hi, lo}, exp);
    mhi = exp[63:32];
    mlo = exp[31:0];
  endtask

  logic [5:0] codes [12] = '{FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU,
                             FUNCT_MULT, FUNCT_DIV, FUNCT_MTHI, FUNCT_MTLO,
                             FUNCT_MFHI, FUNCT_MFLO, 6'h20, 6'h2A};

  initial begin
    logic [31:0] ra, rb;
    logic [5:0]  rf;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset:busy", 64'(busy), 64'd0);
    checkOutput("reset:hilo", {hi, lo}, 64'd0);
    rst_n = 1'b1;
    tick();

    applyStimulus("mthi", FUNCT_MTHI, 32'h1234_5678, 32'h0);
    applyStimulus("mtlo", FUNCT_MTLO, 32'hCAFE_0001, 32'h0);
    applyStimulus("multu_max", FUNCT_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    applyStimulus("mult_m1", FUNCT_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    applyStimulus("div_m7_2", FUNCT_DIV, 32'hFFFF_FFF9, 32'd2);
    applyStimulus("divu_100_7", FUNCT_DIVU, 32'd100, 32'd7);
    applyStimulus("div_ovf", FUNCT_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    applyStimulus("divu_by0", FUNCT_DIVU, 32'd5, 32'd0);
    applyStimulus("div_m5_by0", FUNCT_DIV, 32'hFFFF_FFFB, 32'd0);
    applyStimulus("div_5_by0", FUNCT_DIV, 32'd5, 32'd0);
    applyStimulus("mfhi", FUNCT_MFHI, 32'h5555_AAAA, 32'h1);

    // Requests raised while busy must be dropped without disturbing the run.
    busy_cnt = 0;
    start = 1'b1; fncode = FUNCT_MULT; op_a = 32'd7; op_b = 32'hFFFF_FFFD;
    tick();
    start = 1'b0;
    repeat (3) tick();
    start = 1'b1; fncode = FUNCT_MTHI; op_a = 32'hDEAD_BEEF; op_b = '0;
    tick();
    fncode = FUNCT_MULT; op_a = 32'd5; op_b = 32'd5;
    tick();
    start = 1'b0;
    checkOutput("ignore:hold", {hi, lo}, {mhi, mlo});
    waitIdle("ignore");
    checkOutput("ignore:busy", 64'(busy_cnt), 64'd33);
    checkOutput("ignore:hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    mhi = hi === 32'hFFFF_FFFF ? 32'hFFFF_FFFF : mhi;
    mlo = lo === 32'hFFFF_FFEB ? 32'hFFFF_FFEB : mlo;
    applyStimulus("e34_mtlo", FUNCT_MTLO, 32'h0BAD_F00D, 32'h0);

    // Asynchronous reset in the middle of a run.
    busy_cnt = 0;
    start = 1'b1; fncode = FUNCT_MULTU; op_a = 32'hFFFF_0000; op_b = 32'h1234_5678;
    tick();
    start = 1'b0;
    repeat (15) tick();
    #2 rst_n = 1'b0;
    #1;
    checkOutput("areset:busy", 64'(busy), 64'd0);
    checkOutput("areset:hilo", {hi, lo}, 64'd0);
    #2 rst_n = 1'b1;
    mhi = '0;
    mlo = '0;
    tick();
    applyStimulus("multu_3x4", FUNCT_MULTU, 32'd3, 32'd4);

    for (int i = 0; i < 60; i++) begin
      rf = codes[$urandom_range(0, 11)];
      ra = $urandom();
      rb = $urandom();
      case ($urandom_range(0, 9))
        0: rb = 32'd0;
        1: rb = 32'hFFFF_FFFF;
        2: ra = 32'h8000_0000;
        3: begin ra = $urandom_range(0, 1000); rb = $urandom_range(1, 40); end
        default: ;
      endcase
      applyStimulus($sformatf("rand%0d", i), rf, ra, rb);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- HI/LO multiply/divide unit: the consumer of the 6-bit ALU function code for the MIPS HI/LO instruction group (MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI, MFLO).
- Sits beside the ALU in the execute stage and holds the architectural HI and LO registers.
- Multiply and divide are iterative, one bit per cycle; the unit raises busy so the CPU stalls until results settle.

Parameters:
- WIDTH, 32, operand and HI/LO register width; iteration count equals WIDTH.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous reset, active-low
- start  in  1  request strobe; fncode/op_a/op_b valid this cycle
- fncode  in  6  ALU function code (FUNCT_* values)
- op_a  in  WIDTH  rs value: multiplicand / dividend / MTHI-MTLO source
- op_b  in  WIDTH  rt value: multiplier / divisor
- busy  out  1  iterative operation in progress; CPU must stall HI/LO users
- hi  out  WIDTH  HI register (MFHI read data)
- lo  out  WIDTH  LO register (MFLO read data)

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset: immediate, from any state including mid-operation. State=IDLE, busy=0, hi=0, lo=0, counter=0, partial results cleared.
- Accept rule: start is sampled only when busy=0. While busy=1, start is ignored (no queueing, no abort).
- Codes that have no effect on start: MFHI/MFLO (reads are combinational from hi/lo), and any code outside the HI/LO group.
- MTHI / MTLO (start, busy=0): hi<=op_a or lo<=op_a at that edge. busy stays 0. Single cycle.
- MULT/MULTU/DIV/DIVU (start, busy=0, edge E0):
  - Latch operands; for signed ops latch magnitudes plus result-sign flags.
  - State -> RUN, counter=0, busy=1.
- RUN: one shift-add (multiply) or restoring shift-subtract (divide) step per cycle. Counter increments. After WIDTH steps (edges E1..E32), state -> FIX.
- FIX: apply sign correction, then write hi/lo at edge E33. State -> IDLE, busy=0 after E33.
  - hi/lo hold their old values until E33. A new start is accepted at E34 or later.
- Multiply results: {hi,lo} = 64-bit product. MULT is two's-complement signed; MULTU is unsigned.
- Divide results: lo = quotient, hi = remainder.
  - Signed quotient truncates toward zero; remainder takes the dividend's sign.
- Divide by zero (deterministic, not trapped):
  - DIVU: lo=all ones, hi=op_a.
  - DIV: lo = +1 if op_a negative, else all ones (negated restoring result); hi=op_a.
- Signed overflow: DIV of -2^(WIDTH-1) by -1 gives lo=0x8000_0000, hi=0.
- Simultaneous events:
  - MTHI/MTLO issued while busy=1 is ignored; the CPU is responsible for stalling it.
  - Reset during RUN/FIX discards the operation.
- No output is X after reset. Outputs are registered except via the hi/lo register read path.

Decomposition:
- The shared opcode/funct package (FUNCT_MULT=6'h18, FUNCT_MULTU=6'h19, FUNCT_DIV=6'h1A, FUNCT_DIVU=6'h1B, FUNCT_MFHI=6'h10, FUNCT_MTHI=6'h11, FUNCT_MFLO=6'h12, FUNCT_MTLO=6'h13) gains any missing constants.
- Add an enum state_t {IDLE, RUN, FIX} to the same package.
- One sub-module, muldiv_step: combinational single iteration taking {acc, q, operand, is_div} and returning the next {acc, q}. The top holds the FSM, counter, sign handling and HI/LO.

Test Plan:
- Reset then MTHI op_a=0x1234_5678, next cycle MTLO op_a=0xCAFE_0001 -> hi=0x1234_5678, lo=0xCAFE_0001, busy never 1.
- MULTU 0xFFFF_FFFF x 0xFFFF_FFFF -> busy 1 for exactly 33 cycles; hi=0xFFFF_FFFE, lo=0x0000_0001 at E33. MULT with the same operands -> hi=0, lo=1.
- DIV -7 / 2 -> lo=0xFFFF_FFFD (-3), hi=0xFFFF_FFFF (-1). DIVU 100/7 -> lo=14, hi=2. DIV 0x8000_0000 / -1 -> lo=0x8000_0000, hi=0.
- DIVU 5/0 -> lo=0xFFFF_FFFF, hi=5. DIV -5/0 -> lo=1, hi=0xFFFF_FFFB.
- During busy, assert start with MTHI and with MULT -> both ignored; the original result lands at E33 and hi is not overwritten. Start at E34 is accepted.
- Drop rst_n low at RUN cycle 15, between clock edges -> busy, hi and lo go to 0 immediately. After release, a fresh MULTU 3x4 -> lo=12, hi=0.
